// File: rtl/dm_cache_if.sv
// dm_cache_if: CPU request/response and main-memory fetch signals of the cache controller.
interface dm_cache_if #(
    parameter int ADDR_W = 15,
    parameter int CNT_W  = 16
);
    logic              req_valid;
    logic [ADDR_W-1:0] req_addr;
    logic              req_ready;
    logic              resp_valid;
    logic [31:0]       resp_data;
    logic              resp_hit;
    logic              mem_read_en;
    logic [ADDR_W-1:0] mem_addr;
    logic [127:0]      mem_block;
    logic [CNT_W-1:0]  access_count;
    logic [CNT_W-1:0]  hit_count;

    modport slave (
        input  req_valid, req_addr, mem_block,
        output req_ready, resp_valid, resp_data, resp_hit, mem_read_en, mem_addr,
               access_count, hit_count
    );

    modport master (
        output req_valid, req_addr, mem_block,
        input  req_ready, resp_valid, resp_data, resp_hit, mem_read_en, mem_addr,
               access_count, hit_count
    );
endinterface

// File: rtl/dm_cache_controller.sv
// dm_cache_controller: direct-mapped read-only cache with 4-word line fill and saturating hit/access counters.
module dm_cache_controller #(
    parameter int ADDR_W      = 15,
    parameter int INDEX_W     = 10,
    parameter int MEM_LATENCY = 4,
    parameter int CNT_W       = 16
) (
    input  logic       clk,
    input  logic       rst,
    dm_cache_if.slave  bus
);
    localparam int TAG_W = ADDR_W - INDEX_W - 2;
    localparam int LINES = 1 << INDEX_W;
    localparam int CW    = (MEM_LATENCY > 1) ? $clog2(MEM_LATENCY) : 1;

    typedef enum logic [1:0] {IDLE, LOOKUP, MEM_WAIT, RESP} state_t;

    state_t             r_state, w_next;
    logic [ADDR_W-1:0]  r_addr;
    logic [LINES-1:0]   r_valid;
    logic [TAG_W-1:0]   r_tag [LINES];
    logic [127:0]       r_data [LINES];
    logic [CW-1:0]      r_cnt;
    logic [31:0]        r_resp_data;
    logic               r_resp_hit;
    logic               r_mem_rd;
    logic [ADDR_W-1:0]  r_mem_addr;
    logic [CNT_W-1:0]   r_acc, r_hits;

    logic [INDEX_W-1:0] w_idx;
    logic [TAG_W-1:0]   w_tag;
    logic [127:0]       w_line;
    logic               w_hit, w_fill;

    assign w_idx  = r_addr[INDEX_W+1:2];
    assign w_tag  = r_addr[ADDR_W-1:INDEX_W+2];
    assign w_line = r_data[w_idx];
    assign w_hit  = r_valid[w_idx] && (r_tag[w_idx] == w_tag);
    assign w_fill = (r_state == MEM_WAIT) && (r_cnt == '0);

    assign bus.req_ready    = (r_state == IDLE);
    assign bus.resp_valid   = (r_state == RESP);
    assign bus.resp_data    = r_resp_data;
    assign bus.resp_hit     = r_resp_hit;
    assign bus.mem_read_en  = r_mem_rd;
    assign bus.mem_addr     = r_mem_addr;
    assign bus.access_count = r_acc;
    assign bus.hit_count    = r_hits;

    always_ff @(posedge clk) begin
        if (rst) r_state <= IDLE;
        else     r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:     w_next = bus.req_valid ? LOOKUP : IDLE;
            LOOKUP:   w_next = w_hit ? RESP : MEM_WAIT;
            MEM_WAIT: w_next = w_fill ? RESP : MEM_WAIT;
            default:  w_next = IDLE;
        endcase
    end

    // Tag/data storage is not reset; a fill cut short by reset never writes
    always_ff @(posedge clk) begin
        if (!rst && w_fill) begin
            r_tag[w_idx]  <= w_tag;
            r_data[w_idx] <= bus.mem_block;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_addr      <= '0;
            r_valid     <= '0;
            r_cnt       <= '0;
            r_resp_data <= '0;
            r_resp_hit  <= 1'b0;
            r_mem_rd    <= 1'b0;
            r_mem_addr  <= '0;
            r_acc       <= '0;
            r_hits      <= '0;
        end else begin
            if (r_state == IDLE && bus.req_valid) r_addr <= bus.req_addr;
            if (r_state == LOOKUP) begin
                r_acc <= (&r_acc) ? r_acc : r_acc + CNT_W'(1);
                if (w_hit) begin
                    r_hits      <= (&r_hits) ? r_hits : r_hits + CNT_W'(1);
                    r_resp_data <= w_line[32*r_addr[1:0] +: 32];
                    r_resp_hit  <= 1'b1;
                end else begin
                    r_mem_rd   <= 1'b1;
                    r_mem_addr <= {r_addr[ADDR_W-1:2], 2'b00};
                    r_cnt      <= CW'(MEM_LATENCY - 1);
                end
            end
            if (r_state == MEM_WAIT) begin
                if (w_fill) begin
                    r_valid[w_idx] <= 1'b1;
                    r_resp_data    <= bus.mem_block[32*r_addr[1:0] +: 32];
                    r_resp_hit     <= 1'b0;
                    r_mem_rd       <= 1'b0;
                end else begin
                    r_cnt <= r_cnt - CW'(1);
                end
            end
        end
    end
endmodule

// File: tb/tb_dm_cache_controller.sv
// tb_dm_cache_controller: directed and random reads against a line-level cache model and a word memory.
module tb_dm_cache_controller;
    localparam int L       = 4;
    localparam int CW      = 10;
    localparam int CNT_MAX = (1 << CW) - 1;

    logic clk, rst;
    dm_cache_if #(.ADDR_W(15), .CNT_W(CW)) bus ();

    dm_cache_controller #(.ADDR_W(15), .INDEX_W(10), .MEM_LATENCY(L), .CNT_W(CW)) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    logic [31:0] mem [0:32767];
    bit          ref_valid [1024];
    int          ref_tag [1024];
    int          acc_exp, hit_exp;
    int          n_assert, n_fail;

    assign bus.mem_block = {mem[bus.mem_addr + 15'd3], mem[bus.mem_addr + 15'd2],
                            mem[bus.mem_addr + 15'd1], mem[bus.mem_addr]};

    initial begin
        clk = 0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 1024; i++) ref_valid[i] = 0;
        acc_exp = 0;
        hit_exp = 0;
    endtask

    // Records one lookup in the model; returns whether it should hit
    task automatic model_lookup(input logic [14:0] a, output bit hit);
        int idx, tg;
        idx = int'(a[11:2]);
        tg  = int'(a[14:12]);
        hit = ref_valid[idx] && ref_tag[idx] == tg;
        acc_exp = (acc_exp < CNT_MAX) ? acc_exp + 1 : CNT_MAX;
        if (hit) hit_exp = (hit_exp < CNT_MAX) ? hit_exp + 1 : CNT_MAX;
        ref_valid[idx] = 1;
        ref_tag[idx]   = tg;
    endtask

    // Called at a negedge in IDLE; returns at the negedge after the response
    task automatic do_read(input logic [14:0] a);
        bit exp_hit, got, bad_addr;
        int n, nrd;
        chk("req_ready_idle", bus.req_ready, 1);
        bus.req_valid = 1;
        bus.req_addr  = a;
        @(posedge clk);
        #1 bus.req_valid = 0;
        model_lookup(a, exp_hit);
        n = 0; nrd = 0; got = 0; bad_addr = 0;
        while (!got && n < 64) begin
            @(posedge clk);
            n++;
            @(negedge clk);
            if (bus.mem_read_en) begin
                nrd++;
                if (bus.mem_addr !== {a[14:2], 2'b00}) bad_addr = 1;
            end
            if (bus.resp_valid) got = 1;
        end
        chk("resp_seen", got, 1);
        chk("latency", n + 1, exp_hit ? 2 : 2 + L);
        chk("resp_data", bus.resp_data, mem[a]);
        chk("resp_hit", bus.resp_hit, exp_hit);
        chk("mem_rd_cycles", nrd, exp_hit ? 0 : L);
        chk("mem_addr", bad_addr, 0);
        chk("access_count", bus.access_count, acc_exp);
        chk("hit_count", bus.hit_count, hit_exp);
        @(negedge clk);
        chk("resp_one_cycle", bus.resp_valid, 0);
        chk("resp_data_hold", bus.resp_data, mem[a]);
    endtask

    initial begin
        bit got, h;
        int accepts, resps, busy, n;
        n_assert = 0;
        n_fail = 0;
        rst = 1;
        bus.req_valid = 0;
        bus.req_addr  = '0;
        for (int i = 0; i < 32768; i++) mem[i] = $urandom;
        for (int i = 0; i < 4; i++) mem[15'h0400 + i] = 32'd1;
        model_reset();
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 0;
        chk("rst_ready", bus.req_ready, 1);
        chk("rst_resp_valid", bus.resp_valid, 0);
        chk("rst_resp_data", bus.resp_data, 0);
        chk("rst_resp_hit", bus.resp_hit, 0);
        chk("rst_mem_rd", bus.mem_read_en, 0);
        chk("rst_mem_addr", bus.mem_addr, 0);
        chk("rst_acc", bus.access_count, 0);
        chk("rst_hits", bus.hit_count, 0);

        do_read(15'h0400);
        chk("t1_data", bus.resp_data, 1);
        chk("t1_acc", bus.access_count, 1);
        chk("t1_hits", bus.hit_count, 0);
        do_read(15'h0402);
        chk("t2_hits", bus.hit_count, 1);
        do_read(15'h1400);
        do_read(15'h0400);
        chk("t3_conflict_miss", bus.resp_hit, 0);

        for (int i = 0; i < 300; i++)
            do_read({3'($urandom_range(0, 3)), 10'(10'h200 + $urandom_range(0, 7)), 2'($urandom_range(0, 3))});

        // Held request: one accept per IDLE visit, ready low while busy
        bus.req_valid = 1;
        bus.req_addr  = 15'h0500;
        accepts = 0; resps = 0; busy = 0;
        for (int c = 0; c < 20; c++) begin
            if (busy != 0) chk("ready_low_busy", bus.req_ready, 0);
            if (bus.resp_valid) begin
                chk("burst_hit", bus.resp_hit, resps != 0);
                chk("burst_data", bus.resp_data, mem[15'h0500]);
                resps++;
                busy = 0;
            end else if (busy == 0 && bus.req_ready) begin
                accepts++;
                busy = 1;
                model_lookup(15'h0500, h);
            end
            @(posedge clk);
            @(negedge clk);
        end
        bus.req_valid = 0;
        chk("burst_accepts", accepts, 6);
        chk("burst_resps", resps, 5);
        got = 0;
        for (int c = 0; c < 16 && !got; c++) begin
            if (bus.resp_valid) got = 1;
            else begin
                chk("ready_low_drain", bus.req_ready, 0);
                @(negedge clk);
            end
        end
        chk("drain_resp", got, 1);
        chk("drain_hit", bus.resp_hit, 1);
        chk("burst_acc", bus.access_count, acc_exp);
        chk("burst_hits", bus.hit_count, hit_exp);
        @(negedge clk);

        // Reset while the fill is outstanding
        bus.req_valid = 1;
        bus.req_addr  = 15'h2abc;
        @(posedge clk);
        #1 bus.req_valid = 0;
        got = 0;
        for (n = 0; n < 10 && !got; n++) begin
            @(negedge clk);
            if (bus.mem_read_en) got = 1;
        end
        chk("t5_mem_wait", got, 1);
        rst = 1;
        @(posedge clk);
        @(negedge clk);
        rst = 0;
        model_reset();
        chk("t5_ready", bus.req_ready, 1);
        chk("t5_mem_rd", bus.mem_read_en, 0);
        chk("t5_resp_valid", bus.resp_valid, 0);
        chk("t5_acc", bus.access_count, 0);
        chk("t5_hits", bus.hit_count, 0);
        got = 0;
        repeat (8) begin
            @(negedge clk);
            if (bus.resp_valid) got = 1;
        end
        chk("t5_no_resp", got, 0);
        do_read(15'h2abc);
        chk("t5_reread_miss", bus.resp_hit, 0);

        model_reset();
        rst = 1;
        @(posedge clk);
        @(negedge clk);
        rst = 0;
        for (int i = 0; i < CNT_MAX + 80; i++) do_read(15'h0400);
        chk("sat_acc", bus.access_count, CNT_MAX);
        chk("sat_hits", bus.hit_count, CNT_MAX);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
